iob_halfdup_ctrl: RTL and testbench
===================================

# iob_halfdup_ctrl

Half-duplex sequencer for one shared bidirectional pad. Accepts a transaction request (up to DATA_W bits to transmit, then up to DATA_W bits to receive) and drives the tristate pad buffer's data and enable inputs bit-serially, MSB first. It inserts bus-turnaround gaps between drive and release, samples the returned bits, and presents the received word on a valid/ready response port. It sits between a CSR/bit-bang master and the tristate I/O buffer instance.

## Interface
- DATA_W, 8: max bits per direction; ≥1.
- DIV, 4: clock cycles per bit period; ≥2.
- TURN, 2: turnaround length in bit periods; ≥1.
- LEN_W (localparam): $clog2(DATA_W+1).
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready.
- req_tx_data_i  in  DATA_W  bits to send, right-aligned.
- req_tx_len_i  in  LEN_W  bits to send, 0..DATA_W.
- req_rx_len_i  in  LEN_W  bits to receive, 0..DATA_W.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response ready.
- rsp_data_o  out  DATA_W  received bits, right-aligned, zero-extended.
- pad_out_o  out  1  to buffer data input.
- pad_en_o  out  1  to buffer drive enable.
- pad_in_i  in  1  from buffer output.
- busy_o  out  1  state ≠ IDLE.

## Operation
- States: IDLE, TX, TURN, RX, RESP, GAP.
- IDLE: req_ready_o = (state==IDLE) & !rst_i. Handshake on valid&ready latches data/lengths. Next state: TX if tx_len>0; else TURN if rx_len>0; else RESP.
- TX: pad_en_o=1; pad_out_o = bit tx_len-1-i of the latched data during bit i; each bit held DIV cycles. After last bit: TURN if rx_len>0, else RESP.
- TURN: pad_en_o=0, pad_out_o=0 for TURN·DIV cycles, then RX.
- RX: pad released. Sample pad_in_i at cycle index DIV/2 (0-based, integer division) of each bit period. Shift into LSB (first received bit ends up MSB of the rx_len-bit field). After rx_len bits → RESP.
- RESP: rsp_valid_o=1; rsp_data_o stable until rsp_valid&rsp_ready, then GAP.
- GAP: pad released for TURN·DIV cycles, then IDLE. Guarantees turnaround before the next drive.
- Lengths > DATA_W are clamped to DATA_W.
- req_valid_i outside IDLE is ignored (not latched).
- Reset values: req_ready_o 0 while rst_i high, 1 afterwards; rsp_valid_o 0; rsp_data_o 0; pad_out_o 0; pad_en_o 0; busy_o 0; state IDLE.
- Reset mid-operation aborts the transaction. No response is produced and the pad is released.

## Timing
- pad_out_o and pad_en_o are registered. With the request accepted at edge k, the first TX bit appears in cycle k+1.
- Bit-period counter runs 0..DIV-1 and wraps; the bit counter advances on wrap.
- rsp_valid_o first high at cycle k+1+DIV·(tx_len+T+rx_len), where T=TURN if rx_len>0 else 0.
- Both lengths 0: rsp_valid_o at k+1; pad_en_o never asserted.
- req_ready_o returns TURN·DIV+1 cycles after the response handshake edge.
- pad_en_o falls in the cycle after the last TX bit period; there is never a cycle with pad_en_o=1 in RX.

## Structure
- Package iob_halfdup_pkg holds:
  - state encoding localparams (3-bit)
  - the LEN_W width function
- Sub-module iob_halfdup_bit_timer: DIV counter with wrap, mid-bit sample strobe, and a down-counter of bit periods loaded per state. It is reused for TX, TURN, RX and GAP.
- The tristate buffer is instantiated at the pad level, not inside this block.

## Test plan
All scenarios use DATA_W=8, DIV=4, TURN=2.
- TX only: tx 0xA5, len 8, rx_len 0 → pad_en_o high for 32 cycles from k+1, bits 1,0,1,0,0,1,0,1 each 4 cycles; rsp_valid_o at k+33 with data 0x00.
- TX+RX: tx 0b10, len 2, rx_len 4, pad_in_i 1,0,1,1 → pad_en_o high 8 cycles, then 8 released; rsp_valid_o at k+33 with rsp_data_o 0x0B.
- Null: both lengths 0 → rsp_valid_o at k+1, data 0x00, pad_en_o stays 0, then GAP of 8 cycles.
- Backpressure: rsp_ready_i low 10 cycles → rsp_valid_o/rsp_data_o stable, pad_en_o 0, req_ready_o 0; req_ready_o returns 9 cycles after the handshake edge.
- Reset mid-TX during bit 3 → cycle after rst_i sampled: pad_en_o 0, rsp_valid_o 0, busy_o 0; after release req_ready_o 1, and the next request executes normally.
- Ignored requests and clamping: req_valid_i pulsed during RX is not latched; a tx_len of 15 sends 8 bits.

Source files
------------

// File: rtl/iob_halfdup_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iob_halfdup_pkg
// Description : Shared state encoding and width helper for the half-duplex
//               pad sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package iob_halfdup_pkg;

  localparam int STATE_W = 3;

  // Sequencer states, 3-bit encoding
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_TX   = 3'd1,
    ST_TURN = 3'd2,
    ST_RX   = 3'd3,
    ST_RESP = 3'd4,
    ST_GAP  = 3'd5
  } state_e;

  // Bits needed to hold the values 0..n inclusive
  function automatic int len_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/iob_halfdup_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : iob_halfdup_bit_timer
// Description : Bit-period timer. Counts DIV cycles per period, raises a
//               mid-period sample strobe, and counts down a number of
//               periods loaded at the start of each phase.
// Revision    : 1.0 - initial release
// ============================================================================
module iob_halfdup_bit_timer
  import iob_halfdup_pkg::*;
#(
  parameter int DIV   = 4,
  parameter int PER_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [PER_W-1:0] periods_i,
  input  logic             run_i,
  output logic             sample_o,
  output logic             wrap_o,
  output logic             done_o
);

  localparam int                CNT_W    = $clog2(DIV);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_MID  = CNT_W'(DIV / 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PER_W-1:0] per_q, per_d;

  assign wrap_o   = run_i && (cnt_q == CNT_LAST);
  assign sample_o = run_i && (cnt_q == CNT_MID);
  assign done_o   = wrap_o && (per_q == PER_W'(1));

  // Next-count: a load restarts the period, otherwise count and wrap
  always_comb begin
    cnt_d = cnt_q;
    per_d = per_q;
    if (load_i) begin
      cnt_d = '0;
      per_d = periods_i;
    end else if (run_i) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        per_d = per_q - PER_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      per_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      per_q <= per_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/iob_halfdup_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : iob_halfdup_ctrl
// Description : Half-duplex sequencer for one shared bidirectional pad.
//               Serialises a transmit field MSB first, inserts turnaround
//               gaps, samples a receive field and returns it on a
//               valid/ready response port.
// Revision    : 1.0 - initial release
// ============================================================================
module iob_halfdup_ctrl
  import iob_halfdup_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIV    = 4,
  parameter int TURN   = 2,
  localparam int LEN_W = len_width(DATA_W)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [DATA_W-1:0] req_tx_data_i,
  input  logic [LEN_W-1:0]  req_tx_len_i,
  input  logic [LEN_W-1:0]  req_rx_len_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              pad_out_o,
  output logic              pad_en_o,
  input  logic              pad_in_i,
  output logic              busy_o
);

  localparam int              PER_W   = len_width((DATA_W > TURN) ? DATA_W : TURN);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DATA_W);

  state_e            state_q, state_d;
  logic              pad_en_q, pad_en_d;
  logic              pad_out_q, pad_out_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [LEN_W-1:0]  rx_len_q, rx_len_d;

  logic [LEN_W-1:0]  tx_len_c, rx_len_c;
  logic [DATA_W-1:0] tx_aligned;
  logic              tmr_load, tmr_run, tmr_sample, tmr_wrap, tmr_done;
  logic [PER_W-1:0]  tmr_periods;

  // Over-length requests are clamped; tx data is moved to the top so the
  // shift register always emits from its MSB.
  assign tx_len_c   = (req_tx_len_i > LEN_MAX) ? LEN_MAX : req_tx_len_i;
  assign rx_len_c   = (req_rx_len_i > LEN_MAX) ? LEN_MAX : req_rx_len_i;
  assign tx_aligned = req_tx_data_i << (LEN_MAX - tx_len_c);

  assign tmr_run = (state_q == ST_TX) || (state_q == ST_TURN) ||
                   (state_q == ST_RX) || (state_q == ST_GAP);

  iob_halfdup_bit_timer #(
    .DIV   (DIV),
    .PER_W (PER_W)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (tmr_load),
    .periods_i (tmr_periods),
    .run_i     (tmr_run),
    .sample_o  (tmr_sample),
    .wrap_o    (tmr_wrap),
    .done_o    (tmr_done)
  );

  // Sequencer next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    pad_en_d    = pad_en_q;
    pad_out_d   = pad_out_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    rx_len_d    = rx_len_q;
    tmr_load    = 1'b0;
    tmr_periods = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          rx_len_d = rx_len_c;
          rx_sh_d  = '0;
          if (tx_len_c != '0) begin
            state_d     = ST_TX;
            pad_en_d    = 1'b1;
            pad_out_d   = tx_aligned[DATA_W-1];
            tx_sh_d     = tx_aligned << 1;
            tmr_load    = 1'b1;
            tmr_periods = PER_W'(tx_len_c);
          end else if (rx_len_c != '0) begin
            state_d     = ST_TURN;
            tmr_load    = 1'b1;
            tmr_periods = PER_W'(TURN);
          end else begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
          end
        end
      end
      ST_TX: begin
        if (tmr_done) begin
          pad_en_d  = 1'b0;
          pad_out_d = 1'b0;
          if (rx_len_q != '0) begin
            state_d     = ST_TURN;
            tmr_load    = 1'b1;
            tmr_periods = PER_W'(TURN);
          end else begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
          end
        end else if (tmr_wrap) begin
          pad_out_d = tx_sh_q[DATA_W-1];
          tx_sh_d   = tx_sh_q << 1;
        end
      end
      ST_TURN: begin
        if (tmr_done) begin
          state_d     = ST_RX;
          tmr_load    = 1'b1;
          tmr_periods = PER_W'(rx_len_q);
        end
      end
      ST_RX: begin
        if (tmr_sample) begin
          rx_sh_d = (rx_sh_q << 1) | DATA_W'(pad_in_i);
        end
        if (tmr_done) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = rx_sh_d;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d     = ST_GAP;
          rsp_valid_d = 1'b0;
          tmr_load    = 1'b1;
          tmr_periods = PER_W'(TURN);
        end
      end
      ST_GAP: begin
        if (tmr_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer registers; reset aborts any transaction and releases the pad
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      pad_en_q    <= 1'b0;
      pad_out_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      rx_len_q    <= '0;
    end else begin
      state_q     <= state_d;
      pad_en_q    <= pad_en_d;
      pad_out_q   <= pad_out_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      rx_len_q    <= rx_len_d;
    end
  end

  assign req_ready_o = (state_q == ST_IDLE) && !rst_i;
  assign busy_o      = (state_q != ST_IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign pad_out_o   = pad_out_q;
  assign pad_en_o    = pad_en_q;

endmodule
`default_nettype wire

// File: tb/tb_iob_halfdup_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_iob_halfdup_ctrl
// Description : Directed self-checking bench for iob_halfdup_ctrl
//               (DATA_W=8, DIV=4, TURN=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iob_halfdup_ctrl;

  localparam int DATA_W = 8;
  localparam int DIV    = 4;
  localparam int TURN   = 2;
  localparam int LEN_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] tx_data;
  logic [LEN_W-1:0]  tx_len;
  logic [LEN_W-1:0]  rx_len;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              pad_out;
  logic              pad_en;
  logic              pad_in;
  logic              busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  iob_halfdup_ctrl #(
    .DATA_W (DATA_W),
    .DIV    (DIV),
    .TURN   (TURN)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_tx_data_i (tx_data),
    .req_tx_len_i  (tx_len),
    .req_rx_len_i  (rx_len),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_data_o    (rsp_data),
    .pad_out_o     (pad_out),
    .pad_en_o      (pad_en),
    .pad_in_i      (pad_in),
    .busy_o        (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; land 1 time unit after the rising edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic [3:0] tl, input logic [3:0] rl);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    tx_data   = d;
    tx_len    = tl;
    rx_len    = rl;
    tick;
    req_valid = 1'b0;
  endtask

  // txbits / rxbits are the expected/driven pad bits, first bit in [7]
  task automatic run_txn(input logic [7:0] d, input logic [3:0] tl, input logic [3:0] rl,
                         input int ntx, input int nrx,
                         input logic [7:0] txbits, input logic [7:0] rxbits,
                         input int pulse_c);
    int tper;
    tper = (nrx > 0) ? TURN : 0;
    send(d, tl, rl);
    for (int c = 0; c < DIV * (ntx + tper + nrx); c++) begin
      int   p;
      logic b;
      p = c / DIV;
      chk("busy_valid", {31'd0, rsp_valid}, 32'd0);
      chk("busy_flag", {31'd0, busy}, 32'd1);
      if (p < ntx) begin
        chk("tx_en", {31'd0, pad_en}, 32'd1);
        chk("tx_bit", {31'd0, pad_out}, {31'd0, txbits[7-p]});
        pad_in = 1'b1;
      end else begin
        chk("rel_en", {31'd0, pad_en}, 32'd0);
        chk("rel_out", {31'd0, pad_out}, 32'd0);
        pad_in = 1'b1;
      end
      if (p >= ntx + tper) begin
        b = rxbits[7-(p-ntx-tper)];
        pad_in = ((c % DIV) == DIV / 2) ? b : ~b;
      end
      if (c == pulse_c) begin
        chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
        req_valid = 1'b1;
        tx_data   = 8'hFF;
        tx_len    = 4'd0;
        rx_len    = 4'd0;
      end
      tick;
      req_valid = 1'b0;
    end
    chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rsp_en", {31'd0, pad_en}, 32'd0);
  endtask

  task automatic rsp_hs(input logic [7:0] exp, input int stall);
    for (int s = 0; s < stall; s++) begin
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_data", {24'd0, rsp_data}, {24'd0, exp});
      chk("hold_en", {31'd0, pad_en}, 32'd0);
      chk("hold_ready", {31'd0, req_ready}, 32'd0);
      tick;
    end
    chk("rsp_data", {24'd0, rsp_data}, {24'd0, exp});
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    for (int g = 1; g <= TURN * DIV; g++) begin
      chk("gap_ready", {31'd0, req_ready}, 32'd0);
      chk("gap_en", {31'd0, pad_en}, 32'd0);
      chk("gap_valid", {31'd0, rsp_valid}, 32'd0);
      tick;
    end
    chk("ready_back", {31'd0, req_ready}, 32'd1);
    chk("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    tx_data   = '0;
    tx_len    = '0;
    rx_len    = '0;
    rsp_ready = 1'b0;
    pad_in    = 1'b0;
    tick;
    tick;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
    chk("rst_pad_out", {31'd0, pad_out}, 32'd0);
    chk("rst_pad_en", {31'd0, pad_en}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

    // TX only: 0xA5, 8 bits
    run_txn(8'hA5, 4'd8, 4'd0, 8, 0, 8'hA5, 8'h00, -1);
    rsp_hs(8'h00, 0);

    // TX 2 bits (10) then RX 4 bits (1,0,1,1), with 10 cycles of backpressure
    run_txn(8'h02, 4'd2, 4'd4, 2, 4, 8'b1000_0000, 8'b1011_0000, -1);
    rsp_hs(8'h0B, 10);

    // Null transaction
    run_txn(8'h00, 4'd0, 4'd0, 0, 0, 8'h00, 8'h00, -1);
    rsp_hs(8'h00, 0);

    // Reset during TX bit 3
    send(8'hFF, 4'd8, 4'd0);
    for (int c = 0; c < 13; c++) tick;
    chk("pre_abort_en", {31'd0, pad_en}, 32'd1);
    rst = 1'b1;
    tick;
    chk("abort_en", {31'd0, pad_en}, 32'd0);
    chk("abort_valid", {31'd0, rsp_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_ready", {31'd0, req_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("abort_ready_back", {31'd0, req_ready}, 32'd1);
    run_txn(8'h3C, 4'd4, 4'd0, 4, 0, 8'hC0, 8'h00, -1);
    rsp_hs(8'h00, 0);

    // tx_len 15 clamps to 8; request pulsed during RX is ignored
    run_txn(8'h81, 4'd15, 4'd2, 8, 2, 8'h81, 8'b1000_0000, DIV * (8 + TURN) + 1);
    rsp_hs(8'h02, 0);

    // rx_len 12 clamps to 8
    run_txn(8'h00, 4'd0, 4'd12, 0, 8, 8'h00, 8'hC5, -1);
    rsp_hs(8'hC5, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
